// File: rtl/servo_frame_seq.sv
// ASCII servo command sequencer: snapshots channel pulse widths and a move time, then streams
// "#<ID3>P<PWM4>T<TIME4>!" per enabled channel. Define SERVO_GROUP_FRAME_EN to wrap a scan in '{' '}'.
module servo_frame_seq #(
    parameter int unsigned NUM_CH  = 4,
    parameter int unsigned ID_BASE = 0,
    parameter int unsigned PWM_W   = 12,
    parameter int unsigned TIME_W  = 14,
    parameter int unsigned PWM_MIN = 500,
    parameter int unsigned PWM_MAX = 2500,
    localparam int unsigned CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                    sys_clk,
    input  logic                    sys_rst,
    input  logic                    start,
    input  logic [NUM_CH-1:0]       ch_en,
    input  logic [NUM_CH*PWM_W-1:0] pwm_in,
    input  logic [TIME_W-1:0]       time_in,
    output logic [7:0]              tx_data,
    output logic                    tx_valid,
    input  logic                    tx_ready,
    output logic                    busy,
    output logic [CH_W-1:0]         ch_idx,
    output logic                    seq_done,
    output logic [3:0]              led
);

    localparam int unsigned PTR_W    = $clog2(NUM_CH + 1);
    localparam int unsigned TIME_MAX = 9999;
    localparam logic [7:0]  C_HASH   = 8'h23;
    localparam logic [7:0]  C_P      = 8'h50;
    localparam logic [7:0]  C_T      = 8'h54;
    localparam logic [7:0]  C_BANG   = 8'h21;
    localparam logic [7:0]  C_LBRACE = 8'h7B;
    localparam logic [7:0]  C_RBRACE = 8'h7D;

`ifdef SERVO_GROUP_FRAME_EN
    localparam bit GROUP_EN = 1'b1;
`else
    localparam bit GROUP_EN = 1'b0;
`endif

    typedef enum logic [2:0] {S_IDLE, S_SEEK, S_LOAD, S_CONV, S_SEND, S_DONE} state_t;

    state_t                  r_state;
    logic [NUM_CH-1:0]       r_en;
    logic [NUM_CH*PWM_W-1:0] r_pwm;
    logic [TIME_W-1:0]       r_time;
    logic [PTR_W-1:0]        r_ptr;
    logic [3:0]              r_cnt;
    logic [3:0]              r_bidx;
    logic [31:0]             r_sh_id;
    logic [31:0]             r_sh_pwm;
    logic [31:0]             r_sh_time;
    logic                    r_open;
    logic                    r_close;

    logic                    w_found;
    logic [CH_W-1:0]         w_sel;
    logic [PWM_W-1:0]        w_pwm_raw;
    logic [15:0]             w_pwm_cl;
    logic [15:0]             w_time_cl;
    logic [15:0]             w_id;
    logic [3:0]              w_nidx;
    logic [7:0]              w_next_byte;

    // One shift-add-3 step: upper 16 bits BCD, lower 16 bits binary.
    function automatic logic [31:0] dd_step(input logic [31:0] x);
        logic [31:0] y;
        y = x;
        for (int d = 0; d < 4; d++) begin
            if (y[16+4*d +: 4] >= 4'd5) y[16+4*d +: 4] = y[16+4*d +: 4] + 4'd3;
        end
        return {y[30:0], 1'b0};
    endfunction

    function automatic logic [7:0] dig(input logic [3:0] b);
        return 8'h30 + {4'h0, b};
    endfunction

    // Lowest enabled channel at or above the pointer.
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (r_en[i] && (PTR_W'(i) >= r_ptr)) begin
                w_found = 1'b1;
                w_sel   = CH_W'(i);
            end
        end
    end

    always_comb begin
        w_pwm_raw = r_pwm[32'(ch_idx) * PWM_W +: PWM_W];
        if (32'(w_pwm_raw) < PWM_MIN)      w_pwm_cl = 16'(PWM_MIN);
        else if (32'(w_pwm_raw) > PWM_MAX) w_pwm_cl = 16'(PWM_MAX);
        else                               w_pwm_cl = 16'(w_pwm_raw);
        w_time_cl = (32'(r_time) > TIME_MAX) ? 16'(TIME_MAX) : 16'(r_time);
        w_id      = 16'(ID_BASE + 32'(ch_idx));
    end

    // Byte that follows the one currently on tx_data within a frame.
    always_comb begin
        w_nidx      = r_bidx + 4'd1;
        w_next_byte = 8'h00;
        case (w_nidx)
            4'd1:    w_next_byte = dig(r_sh_id[27:24]);
            4'd2:    w_next_byte = dig(r_sh_id[23:20]);
            4'd3:    w_next_byte = dig(r_sh_id[19:16]);
            4'd4:    w_next_byte = C_P;
            4'd5:    w_next_byte = dig(r_sh_pwm[31:28]);
            4'd6:    w_next_byte = dig(r_sh_pwm[27:24]);
            4'd7:    w_next_byte = dig(r_sh_pwm[23:20]);
            4'd8:    w_next_byte = dig(r_sh_pwm[19:16]);
            4'd9:    w_next_byte = C_T;
            4'd10:   w_next_byte = dig(r_sh_time[31:28]);
            4'd11:   w_next_byte = dig(r_sh_time[27:24]);
            4'd12:   w_next_byte = dig(r_sh_time[23:20]);
            4'd13:   w_next_byte = dig(r_sh_time[19:16]);
            4'd14:   w_next_byte = C_BANG;
            default: w_next_byte = 8'h00;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state   <= S_IDLE;
            tx_data   <= '0;
            tx_valid  <= 1'b0;
            busy      <= 1'b0;
            ch_idx    <= '0;
            seq_done  <= 1'b0;
            led       <= '0;
            r_en      <= '0;
            r_pwm     <= '0;
            r_time    <= '0;
            r_ptr     <= '0;
            r_cnt     <= '0;
            r_bidx    <= '0;
            r_sh_id   <= '0;
            r_sh_pwm  <= '0;
            r_sh_time <= '0;
            r_open    <= 1'b0;
            r_close   <= 1'b0;
        end else begin
            seq_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_en    <= ch_en;
                        r_pwm   <= pwm_in;
                        r_time  <= time_in;
                        r_ptr   <= '0;
                        r_open  <= GROUP_EN;
                        busy    <= 1'b1;
                        r_state <= S_SEEK;
                    end
                end
                S_SEEK: begin
                    if (w_found) begin
                        ch_idx  <= w_sel;
                        r_state <= S_LOAD;
                    end else if (GROUP_EN && !r_open) begin
                        // At least one frame went out: close the group.
                        tx_data  <= C_RBRACE;
                        tx_valid <= 1'b1;
                        r_close  <= 1'b1;
                        r_state  <= S_SEND;
                    end else begin
                        seq_done <= 1'b1;
                        led      <= led + 4'd1;
                        r_state  <= S_DONE;
                    end
                end
                S_LOAD: begin
                    r_sh_id   <= {16'h0000, w_id};
                    r_sh_pwm  <= {16'h0000, w_pwm_cl};
                    r_sh_time <= {16'h0000, w_time_cl};
                    r_cnt     <= '0;
                    r_state   <= S_CONV;
                end
                S_CONV: begin
                    r_sh_id   <= dd_step(r_sh_id);
                    r_sh_pwm  <= dd_step(r_sh_pwm);
                    r_sh_time <= dd_step(r_sh_time);
                    r_cnt     <= r_cnt + 4'd1;
                    if (r_cnt == 4'd15) begin
                        tx_valid <= 1'b1;
                        tx_data  <= r_open ? C_LBRACE : C_HASH;
                        r_bidx   <= '0;
                        r_state  <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (tx_ready) begin
                        if (r_close) begin
                            tx_valid <= 1'b0;
                            r_close  <= 1'b0;
                            seq_done <= 1'b1;
                            led      <= led + 4'd1;
                            r_state  <= S_DONE;
                        end else if (r_open) begin
                            r_open  <= 1'b0;
                            tx_data <= C_HASH;
                        end else if (r_bidx == 4'd14) begin
                            tx_valid <= 1'b0;
                            r_ptr    <= PTR_W'(ch_idx) + PTR_W'(1);
                            r_state  <= S_SEEK;
                        end else begin
                            r_bidx  <= w_nidx;
                            tx_data <= w_next_byte;
                        end
                    end
                end
                S_DONE: begin
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_servo_frame_seq.sv
// Directed bench for servo_frame_seq: expected bytes are queued at each start and popped on each transfer.
module tb_servo_frame_seq;

    localparam int unsigned NUM_CH  = 4;
    localparam int unsigned PWM_W   = 12;
    localparam int unsigned TIME_W  = 14;
    localparam int unsigned ID_BASE = 0;
    localparam int unsigned PWM_MIN = 500;
    localparam int unsigned PWM_MAX = 2500;

    logic                    clk = 1'b0;
    logic                    sys_rst;
    logic                    start;
    logic [NUM_CH-1:0]       ch_en;
    logic [NUM_CH*PWM_W-1:0] pwm_in;
    logic [TIME_W-1:0]       time_in;
    logic [7:0]              tx_data;
    logic                    tx_valid;
    logic                    tx_ready;
    logic                    busy;
    logic [1:0]              ch_idx;
    logic                    seq_done;
    logic [3:0]              led;

    always #5 clk = ~clk;

    servo_frame_seq #(
        .NUM_CH (NUM_CH),
        .ID_BASE(ID_BASE),
        .PWM_W  (PWM_W),
        .TIME_W (TIME_W),
        .PWM_MIN(PWM_MIN),
        .PWM_MAX(PWM_MAX)
    ) dut (
        .sys_clk (clk),
        .sys_rst (sys_rst),
        .start   (start),
        .ch_en   (ch_en),
        .pwm_in  (pwm_in),
        .time_in (time_in),
        .tx_data (tx_data),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .busy    (busy),
        .ch_idx  (ch_idx),
        .seq_done(seq_done),
        .led     (led)
    );

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_q[$];
    int         cyc = 0;
    int         xfer_cnt = 0;
    int         done_cnt = 0;
    int         stall_n = 0;
    int         gap_n = 0;
    int         start_cyc = 0;
    int         first_valid_cyc = 0;
    int         last_valid_cyc = 0;
    int         ready_mode = 0;
    bit         gap_chk = 1'b0;
    logic       prev_valid = 1'b0;
    logic       prev_ready = 1'b0;
    logic       prev_rst = 1'b1;
    logic [7:0] prev_data = 8'h00;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // One clock: update tx_ready, then sample outputs at the falling edge and score them.
    task automatic tick();
        logic [7:0] exp_b;
        @(negedge clk);
        cyc++;
        case (ready_mode)
            0:       tx_ready = 1'b1;
            1:       tx_ready = 1'($urandom_range(0, 1));
            default: tx_ready = 1'b0;
        endcase
        if (prev_valid && !prev_ready && !prev_rst) begin
            checks++;
            stall_n++;
            assert (tx_valid === 1'b1 && tx_data === prev_data) else begin
                errors++;
                $error("FAIL hold_stable: valid=%b data=%h, expected valid=1 data=%h", tx_valid, tx_data, prev_data);
            end
        end
        if (tx_valid === 1'b1 && tx_ready && !sys_rst) begin
            exp_b = 8'hxx;
            if (exp_q.size() > 0) exp_b = exp_q.pop_front();
            checks++;
            assert (tx_data === exp_b) else begin
                errors++;
                $error("FAIL tx_byte[%0d]: observed %h expected %h", xfer_cnt, tx_data, exp_b);
            end
            xfer_cnt++;
        end
        if (busy !== 1'b1) last_valid_cyc = 0;
        if (gap_chk && tx_valid === 1'b1 && !prev_valid && last_valid_cyc != 0) begin
            checks++;
            gap_n++;
            assert ((cyc - last_valid_cyc - 1) === 18) else begin
                errors++;
                $error("FAIL frame_gap: observed %0d expected 18", cyc - last_valid_cyc - 1);
            end
        end
        if (tx_valid === 1'b1) last_valid_cyc = cyc;
        if (tx_valid === 1'b1 && first_valid_cyc == 0) first_valid_cyc = cyc;
        if (seq_done === 1'b1) done_cnt++;
        prev_valid = (tx_valid === 1'b1);
        prev_ready = tx_ready;
        prev_rst   = sys_rst;
        prev_data  = tx_data;
    endtask

    function automatic logic [7:0] dg(input int v);
        return 8'(8'h30 + v);
    endfunction

    task automatic push_frame(input int id, input int pwm, input int tm);
        int p;
        int t;
        p = (pwm < int'(PWM_MIN)) ? int'(PWM_MIN) : ((pwm > int'(PWM_MAX)) ? int'(PWM_MAX) : pwm);
        t = (tm > 9999) ? 9999 : tm;
        exp_q.push_back(8'h23);
        exp_q.push_back(dg(id / 100));
        exp_q.push_back(dg((id / 10) % 10));
        exp_q.push_back(dg(id % 10));
        exp_q.push_back(8'h50);
        exp_q.push_back(dg(p / 1000));
        exp_q.push_back(dg((p / 100) % 10));
        exp_q.push_back(dg((p / 10) % 10));
        exp_q.push_back(dg(p % 10));
        exp_q.push_back(8'h54);
        exp_q.push_back(dg(t / 1000));
        exp_q.push_back(dg((t / 100) % 10));
        exp_q.push_back(dg((t / 10) % 10));
        exp_q.push_back(dg(t % 10));
        exp_q.push_back(8'h21);
    endtask

    // Queue the expected stream, then pulse start; returns in cycle 1 after the start edge.
    task automatic do_scan(input logic [3:0] en, input int p0, input int p1, input int p2, input int p3, input int tm);
        int p[4];
        p[0] = p0; p[1] = p1; p[2] = p2; p[3] = p3;
`ifdef SERVO_GROUP_FRAME_EN
        if (en != 4'b0000) exp_q.push_back(8'h7B);
`endif
        for (int i = 0; i < 4; i++) if (en[i]) push_frame(int'(ID_BASE) + i, p[i], tm);
`ifdef SERVO_GROUP_FRAME_EN
        if (en != 4'b0000) exp_q.push_back(8'h7D);
`endif
        ch_en   = en;
        pwm_in  = {12'(p3), 12'(p2), 12'(p1), 12'(p0)};
        time_in = 14'(tm);
        start   = 1'b1;
        start_cyc       = cyc;
        first_valid_cyc = 0;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 3000) begin
            tick();
            n++;
        end
        check("scan_terminates_busy", 32'(busy), 0);
        check("queue_drained", exp_q.size(), 0);
    endtask

    initial begin
        int d0;
        int led0;
        int base;
        int n;
        sys_rst = 1'b1;
        start   = 1'b0;
        ch_en   = '0;
        pwm_in  = '0;
        time_in = '0;
        tx_ready = 1'b1;
        repeat (3) tick();
        check("rst_tx_valid", 32'(tx_valid), 0);
        check("rst_tx_data", 32'(tx_data), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_led", 32'(led), 0);
        check("rst_seq_done", 32'(seq_done), 0);
        check("rst_ch_idx", 32'(ch_idx), 0);
        sys_rst = 1'b0;
        tick();

        // Single channel, nominal values
        d0 = done_cnt;
        do_scan(4'b0001, 1500, 0, 0, 0, 1000);
        check("busy_after_start", 32'(busy), 1);
        wait_idle();
        check("first_valid_latency", first_valid_cyc - start_cyc, 19);
        check("single_done_pulses", done_cnt - d0, 1);
        check("single_led", 32'(led), 1);

        // Two sparse channels with clamping on both ends and on time
        d0 = done_cnt;
`ifdef SERVO_GROUP_FRAME_EN
        gap_chk = 1'b0;
`else
        gap_chk = 1'b1;
`endif
        gap_n = 0;
        do_scan(4'b1010, 0, 2600, 0, 100, 12000);
        wait_idle();
        gap_chk = 1'b0;
`ifndef SERVO_GROUP_FRAME_EN
        check("multi_gap_count", gap_n, 1);
`endif
        check("multi_latency", first_valid_cyc - start_cyc, 19);
        check("multi_last_ch_idx", 32'(ch_idx), 3);
        check("multi_done_pulses", done_cnt - d0, 1);
        check("multi_led", 32'(led), 2);

        // Pseudo-random backpressure across all channels
        d0 = done_cnt;
        stall_n = 0;
        ready_mode = 1;
        do_scan(4'b1111, 1234, 999, 2501, 500, 42);
        wait_idle();
        ready_mode = 0;
        check("bp_done_pulses", done_cnt - d0, 1);
        check("bp_led", 32'(led), 3);
        check("bp_saw_stalls", 32'(stall_n > 0), 1);

        // Empty mask: SEEK then DONE, no bytes
        d0 = done_cnt;
        do_scan(4'b0000, 1500, 1500, 1500, 1500, 1000);
        check("empty_cycle1_seq_done", 32'(seq_done), 0);
        tick();
        check("empty_cycle2_seq_done", 32'(seq_done), 1);
        check("empty_cycle2_tx_valid", 32'(tx_valid), 0);
        tick();
        check("empty_cycle3_seq_done", 32'(seq_done), 0);
        check("empty_cycle3_busy", 32'(busy), 0);
        wait_idle();
        check("empty_done_pulses", done_cnt - d0, 1);
        check("empty_led", 32'(led), 4);

        // start re-asserted mid-scan must be ignored
        d0 = done_cnt;
        led0 = int'(led);
        do_scan(4'b0100, 0, 0, 777, 0, 3000);
        repeat (5) tick();
        ch_en = 4'b1111;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_idle();
        check("restart_done_pulses", done_cnt - d0, 1);
        check("restart_led", 32'(led), 32'(4'(led0 + 1)));
        repeat (3) tick();
        check("restart_stays_idle", 32'(busy), 0);

        // Reset while byte 7 of a frame is on the bus
        do_scan(4'b0001, 2000, 0, 0, 0, 1500);
        base = xfer_cnt;
        n = 0;
        while ((xfer_cnt - base) < 8 && n < 200) begin
            tick();
            n++;
        end
        check("reached_byte7", xfer_cnt - base, 8);
        exp_q.delete();
        sys_rst = 1'b1;
        tick();
        sys_rst = 1'b0;
        check("midrst_tx_valid", 32'(tx_valid), 0);
        check("midrst_busy", 32'(busy), 0);
        check("midrst_led", 32'(led), 0);
        repeat (3) tick();
        check("midrst_silent", 32'(tx_valid), 0);
        d0 = done_cnt;
        do_scan(4'b0001, 1500, 0, 0, 0, 1000);
        wait_idle();
        check("post_rst_done_pulses", done_cnt - d0, 1);
        check("post_rst_led", 32'(led), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/servo_frame_seq.md
Name: servo_frame_seq

Overview:
- Parametrised multi-channel ASCII servo command sequencer.
- Snapshots per-channel pulse widths and a shared move time, converts them to decimal, and streams frames of the form "#<ID3>P<PWM4>T<TIME4>!" byte-by-byte to a UART transmitter over a valid/ready handshake.
- Sits between the servo control logic and the UART TX block.
- Replaces fixed, hard-coded command strings with runtime values, a channel mask and multi-channel scanning.

Parameters:
- NUM_CH, 4, number of servo channels, 1..16.
- ID_BASE, 0, servo ID of channel 0; ID_BASE+NUM_CH-1 must be <= 999.
- PWM_W, 12, width of each pulse-width field in microseconds.
- TIME_W, 14, width of the move-time field in milliseconds.
- PWM_MIN, 500, lower clamp for pulse width.
- PWM_MAX, 2500, upper clamp for pulse width.

Ports:
- sys_clk  in  1  system clock; all logic on the rising edge.
- sys_rst  in  1  synchronous reset, active-high.
- start  in  1  begins a scan when sampled high in IDLE.
- ch_en  in  NUM_CH  channel enable mask, sampled with start.
- pwm_in  in  NUM_CH*PWM_W  pulse widths; channel i occupies bits [i*PWM_W +: PWM_W]; sampled with start.
- time_in  in  TIME_W  move time, sampled with start.
- tx_data  out  8  ASCII byte to the UART.
- tx_valid  out  1  tx_data is valid.
- tx_ready  in  1  UART accepts the byte.
- busy  out  1  high from the cycle after start until the return to IDLE.
- ch_idx  out  clog2(NUM_CH) (minimum 1)  channel currently being sent.
- seq_done  out  1  one-cycle pulse at scan completion.
- led  out  4  low 4 bits of the completed-scan counter.

Behaviour:
- Reset (sys_rst=1 at a clock edge): state=IDLE, tx_data=0, tx_valid=0, busy=0, ch_idx=0, seq_done=0, led=0, snapshot registers cleared. This applies at any point in a scan; the frame in progress is abandoned with no further bytes.
- States: IDLE, SEEK, LOAD, CONV, SEND, DONE.
- IDLE:
  - start=1 latches ch_en, pwm_in and time_in, and sets the channel pointer to 0.
  - Next state is SEEK.
  - start is ignored in every other state.
- SEEK (1 cycle):
  - Finds the lowest enabled channel at or above the pointer and goes to LOAD.
  - If none remain, goes to DONE.
- LOAD (1 cycle):
  - Clamps PWM to [PWM_MAX ≥ x ≥ PWM_MIN] and time to ≤ 9999.
  - Computes ID = ID_BASE + channel.
  - Loads three double-dabble shifters, each 16-bit binary plus 16-bit BCD.
- CONV (exactly 16 cycles):
  - Parallel shift-add-3 conversion of ID, PWM and time.
  - Then goes to SEND with a byte index of 0.
- SEND:
  - Emits 15 bytes in order: '#', ID hundreds, ID tens, ID units, 'P', 4 PWM digits (MS first), 'T', 4 time digits, '!'.
  - Digits are encoded as 8'h30 + BCD.
  - tx_valid is high throughout SEND.
  - A transfer occurs when tx_valid && tx_ready at a clock edge; the byte index then advances.
  - tx_data must stay stable while tx_valid=1 and tx_ready=0.
  - After byte 14 transfers: pointer = channel+1, next state SEEK.
- DONE (1 cycle): seq_done=1, scan counter +1 (wraps mod 16), busy=0 on exit, returns to IDLE.
- Timing with tx_ready held high:
  - The first tx_valid occurs 19 cycles after the start sample edge (SEEK, LOAD, 16×CONV, then SEND).
  - A frame occupies 15 cycles.
  - Inter-frame gap is 18 cycles.
- An all-zero ch_en produces no bytes; seq_done pulses 2 cycles after start (SEEK, DONE).
- The channel pointer never wraps within a scan; channel NUM_CH-1 is the last.

Optional Feature:
- Macro: SERVO_GROUP_FRAME_EN.
- Defined: the scan is wrapped as one group command.
  - '{' is sent in the first SEND slot before the first frame.
  - '}' is sent after the last frame, before DONE.
  - Each wrapper is a single byte under the same handshake.
  - An all-zero mask sends nothing.
- Undefined: no wrapper bytes, exactly as described in Behaviour.

Test Plan:
- Single channel: ch_en=4'b0001, pwm ch0=1500, time=1000, tx_ready=1 -> 15 bytes "#000P1500T1000!", first tx_valid 19 cycles after start, seq_done once, led=1.
- Multi-channel with clamping: ch_en=4'b1010, ch1=2600, ch3=100, time=12000, ID_BASE=0 -> "#001P2500T9999!" then "#003P0500T9999!", an 18-cycle gap between them, nothing for ch0 or ch2.
- Backpressure: tx_ready toggled pseudo-randomly -> tx_data constant while tx_valid && !tx_ready, byte order unchanged, no byte dropped or duplicated.
- Edge cases: ch_en=0 -> no tx_valid, seq_done 2 cycles after start; start re-asserted while busy -> ignored, scan count still increments by exactly 1.
- Reset mid-frame: sys_rst asserted at SEND byte 7 -> next cycle tx_valid=0, busy=0, led=0; a subsequent start yields a complete, correct frame.
- With SERVO_GROUP_FRAME_EN defined, ch_en=4'b0011, pwm 1500/2000, time 500 -> "{#000P1500T0500!#001P2000T0500!}".
